// File: rtl/av2_ivf_demux.sv
// IVF container demultiplexer: checks the 32-byte file header, strips 12-byte frame headers
// and packs payload bytes into little-endian beats. Optional timestamp capture: IVF_FRAME_TS_EN.
module av2_ivf_demux #(
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_FRAME_BYTES = 1048576
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        in_byte,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [$clog2(DATA_WIDTH/8):0]     out_bytes,
  output logic [31:0]                       ivf_fourcc,
  output logic [15:0]                       ivf_width,
  output logic [15:0]                       ivf_height,
  output logic [31:0]                       frame_size,
  output logic [31:0]                       frame_count,
  output logic [63:0]                       frame_ts,
  output logic                              hdr_error,
  output logic [1:0]                        dbg_state
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(BYTES) + 1;
  localparam logic [31:0] MAX_SIZE = 32'(MAX_FRAME_BYTES);

  localparam logic [1:0] ST_FILE_HDR  = 2'd0;
  localparam logic [1:0] ST_FRAME_HDR = 2'd1;
  localparam logic [1:0] ST_PAYLOAD   = 2'd2;
  localparam logic [1:0] ST_ERROR     = 2'd3;

  // Handshakes: a byte moves on in_valid && in_ready; a beat moves on out_valid && out_ready.
  // A presented beat holds out_data/out_last/out_bytes steady until it is taken.

  logic [1:0]            r_state;
  logic [5:0]            r_hdr_cnt;
  logic [31:0]           r_size_acc;
  logic [31:0]           r_remaining;
  logic [CW-1:0]         r_fill_cnt;
  logic [DATA_WIDTH-1:0] r_pack;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [CW-1:0]         r_out_bytes;
  logic [31:0]           r_fourcc;
  logic [15:0]           r_width;
  logic [15:0]           r_height;
  logic [31:0]           r_frame_size;
  logic [31:0]           r_frame_count;
  logic                  r_hdr_error;

  logic                  w_in_ready;
  logic                  w_take;
  logic                  w_fh_bad;
  logic [DATA_WIDTH-1:0] w_pack_next;
  logic [CW-1:0]         w_fill_next;
  logic [31:0]           w_rem_next;
  logic                  w_beat_done;

`ifdef IVF_FRAME_TS_EN
  logic [63:0]           r_ts_acc;
  logic [63:0]           r_frame_ts;
  assign frame_ts = r_frame_ts;
`else
  assign frame_ts = '0;
`endif

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_FILE_HDR:  w_in_ready = 1'b1;
      ST_FRAME_HDR: w_in_ready = 1'b1;
      ST_PAYLOAD:   w_in_ready = !r_out_valid;
      default:      w_in_ready = 1'b0;
    endcase
    if (rst) w_in_ready = 1'b0;
  end

  assign w_take = in_valid && w_in_ready;

  // Fixed fields of the file header: "DKIF" signature and header length 32.
  always_comb begin
    w_fh_bad = 1'b0;
    if (w_take && (r_state == ST_FILE_HDR)) begin
      case (r_hdr_cnt)
        6'd0:    w_fh_bad = (in_byte != 8'h44);
        6'd1:    w_fh_bad = (in_byte != 8'h4B);
        6'd2:    w_fh_bad = (in_byte != 8'h49);
        6'd3:    w_fh_bad = (in_byte != 8'h46);
        6'd6:    w_fh_bad = (in_byte != 8'h20);
        6'd7:    w_fh_bad = (in_byte != 8'h00);
        default: w_fh_bad = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_pack_next = r_pack;
    for (int k = 0; k < BYTES; k++) begin
      if (r_fill_cnt == CW'(k)) w_pack_next[8*k +: 8] = in_byte;
    end
    w_fill_next = r_fill_cnt + CW'(1);
    w_rem_next  = r_remaining - 32'd1;
    w_beat_done = (w_fill_next == CW'(BYTES)) || (w_rem_next == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FILE_HDR;
      r_hdr_cnt     <= '0;
      r_size_acc    <= '0;
      r_remaining   <= '0;
      r_fill_cnt    <= '0;
      r_pack        <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_bytes   <= '0;
      r_fourcc      <= '0;
      r_width       <= '0;
      r_height      <= '0;
      r_frame_size  <= '0;
      r_frame_count <= '0;
      r_hdr_error   <= 1'b0;
`ifdef IVF_FRAME_TS_EN
      r_ts_acc      <= '0;
      r_frame_ts    <= '0;
`endif
    end else begin
      case (r_state)
        ST_FILE_HDR: begin
          if (w_take) begin
            case (r_hdr_cnt)
              6'd8:    r_fourcc[7:0]   <= in_byte;
              6'd9:    r_fourcc[15:8]  <= in_byte;
              6'd10:   r_fourcc[23:16] <= in_byte;
              6'd11:   r_fourcc[31:24] <= in_byte;
              6'd12:   r_width[7:0]    <= in_byte;
              6'd13:   r_width[15:8]   <= in_byte;
              6'd14:   r_height[7:0]   <= in_byte;
              6'd15:   r_height[15:8]  <= in_byte;
              default: ;
            endcase
            if (w_fh_bad) begin
              r_state     <= ST_ERROR;
              r_hdr_error <= 1'b1;
            end else if (r_hdr_cnt == 6'd31) begin
              r_state   <= ST_FRAME_HDR;
              r_hdr_cnt <= '0;
            end else begin
              r_hdr_cnt <= r_hdr_cnt + 6'd1;
            end
          end
        end

        ST_FRAME_HDR: begin
          if (w_take) begin
            for (int k = 0; k < 4; k++) begin
              if (r_hdr_cnt == 6'(k)) r_size_acc[8*k +: 8] <= in_byte;
            end
`ifdef IVF_FRAME_TS_EN
            for (int k = 0; k < 8; k++) begin
              if (r_hdr_cnt == 6'(k + 4)) r_ts_acc[8*k +: 8] <= in_byte;
            end
`endif
            if (r_hdr_cnt == 6'd11) begin
              // Size bytes 0-3 are already in r_size_acc; byte 11 is the timestamp MSB.
              r_hdr_cnt     <= '0;
              r_frame_size  <= r_size_acc;
              r_frame_count <= r_frame_count + 32'd1;
`ifdef IVF_FRAME_TS_EN
              r_frame_ts    <= {in_byte, r_ts_acc[55:0]};
`endif
              if (r_size_acc > MAX_SIZE) begin
                r_state     <= ST_ERROR;
                r_hdr_error <= 1'b1;
              end else if (r_size_acc != 32'd0) begin
                r_state     <= ST_PAYLOAD;
                r_remaining <= r_size_acc;
                r_fill_cnt  <= '0;
                r_pack      <= '0;
              end
            end else begin
              r_hdr_cnt <= r_hdr_cnt + 6'd1;
            end
          end
        end

        ST_PAYLOAD: begin
          if (r_out_valid) begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              if (r_out_last) r_state <= ST_FRAME_HDR;
            end
          end else if (w_take) begin
            r_remaining <= w_rem_next;
            if (w_beat_done) begin
              r_out_data  <= w_pack_next;
              r_out_bytes <= w_fill_next;
              r_out_last  <= (w_rem_next == 32'd0);
              r_out_valid <= 1'b1;
              r_fill_cnt  <= '0;
              r_pack      <= '0;
            end else begin
              r_pack     <= w_pack_next;
              r_fill_cnt <= w_fill_next;
            end
          end
        end

        ST_ERROR: begin
          r_out_valid <= 1'b0;
          r_hdr_error <= 1'b1;
        end

        default: begin
          r_state     <= ST_ERROR;
          r_hdr_error <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign out_bytes   = r_out_bytes;
  assign ivf_fourcc  = r_fourcc;
  assign ivf_width   = r_width;
  assign ivf_height  = r_height;
  assign frame_size  = r_frame_size;
  assign frame_count = r_frame_count;
  assign hdr_error   = r_hdr_error;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_av2_ivf_demux.sv
// Directed bench for av2_ivf_demux: file/frame header parsing, beat packing, backpressure,
// error paths and reset recovery. Timestamp expectation follows IVF_FRAME_TS_EN.
module tb_av2_ivf_demux;

  localparam int DW    = 128;
  localparam int BYTES = DW / 8;
  localparam int CW    = $clog2(BYTES) + 1;
  localparam int MAXF  = 1048576;

  logic          clk;
  logic          rst;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [CW-1:0] out_bytes;
  logic [31:0]   ivf_fourcc;
  logic [15:0]   ivf_width;
  logic [15:0]   ivf_height;
  logic [31:0]   frame_size;
  logic [31:0]   frame_count;
  logic [63:0]   frame_ts;
  logic          hdr_error;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_bytes_q[$];
  logic          exp_last_q[$];
  logic [DW-1:0] obs_q[$];
  logic [CW-1:0] obs_bytes_q[$];
  logic          obs_last_q[$];

  av2_ivf_demux #(.DATA_WIDTH(DW), .MAX_FRAME_BYTES(MAXF)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_bytes(out_bytes), .ivf_fourcc(ivf_fourcc), .ivf_width(ivf_width),
    .ivf_height(ivf_height), .frame_size(frame_size), .frame_count(frame_count),
    .frame_ts(frame_ts), .hdr_error(hdr_error), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1, so at the negedge everything is settled.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      obs_q.push_back(out_data);
      obs_bytes_q.push_back(out_bytes);
      obs_last_q.push_back(out_last);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    obs_q.delete(); obs_bytes_q.delete(); obs_last_q.delete();
    exp_q.delete(); exp_bytes_q.delete(); exp_last_q.delete();
  endtask

  task automatic release_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_byte = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_file_hdr(input logic [31:0] fourcc, input logic [15:0] w, input logic [15:0] h);
    logic [7:0] hb[32];
    for (int i = 0; i < 32; i++) hb[i] = 8'h00;
    hb[0] = 8'h44; hb[1] = 8'h4B; hb[2] = 8'h49; hb[3] = 8'h46;
    hb[6] = 8'h20;
    for (int i = 0; i < 4; i++) hb[8+i] = fourcc[8*i +: 8];
    hb[12] = w[7:0];  hb[13] = w[15:8];
    hb[14] = h[7:0];  hb[15] = h[15:8];
    for (int i = 0; i < 32; i++) send_byte(hb[i]);
  endtask

  task automatic send_frame_hdr(input logic [31:0] size, input logic [63:0] ts);
    for (int i = 0; i < 4; i++) send_byte(size[8*i +: 8]);
    for (int i = 0; i < 8; i++) send_byte(ts[8*i +: 8]);
  endtask

  task automatic send_payload(input int npay, input logic [7:0] start, input logic [7:0] step);
    for (int i = 0; i < npay; i++) send_byte(start + 8'(i) * step);
  endtask

  // scoreboard model: chop a payload into little-endian beats
  task automatic expect_frame(input int size, input logic [7:0] start, input logic [7:0] step);
    logic [DW-1:0] d;
    int f;
    d = '0;
    f = 0;
    for (int i = 0; i < size; i++) begin
      d[8*f +: 8] = start + 8'(i) * step;
      f++;
      if (f == BYTES || i == size - 1) begin
        exp_q.push_back(d);
        exp_bytes_q.push_back(CW'(f));
        exp_last_q.push_back(i == size - 1);
        d = '0;
        f = 0;
      end
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input int nb, input logic last);
    exp_q.push_back(d);
    exp_bytes_q.push_back(CW'(nb));
    exp_last_q.push_back(last);
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 400) begin
      @(posedge clk);
      #2;
      t++;
    end
  endtask

  task automatic compare_beats(input string tag);
    int n;
    check($sformatf("%s_beats", tag), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), obs_q.pop_front(), exp_q.pop_front());
      check($sformatf("%s_bytes%0d", tag, i), obs_bytes_q.pop_front(), exp_bytes_q.pop_front());
      check($sformatf("%s_last%0d", tag, i), obs_last_q.pop_front(), exp_last_q.pop_front());
    end
    obs_q.delete(); obs_bytes_q.delete(); obs_last_q.delete();
    exp_q.delete(); exp_bytes_q.delete(); exp_last_q.delete();
  endtask

  initial begin
    logic [DW-1:0] snap;
    int t;
    out_ready = 1'b1;
    do_reset();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_hdr_error", hdr_error, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_width", ivf_width, 0);
    release_reset();
    check("post_rst_in_ready", in_ready, 1);

    // 16-byte frame after a valid "AV02" 352x288 header
    send_file_hdr(32'h32305641, 16'd352, 16'd288);
    check("fourcc", ivf_fourcc, 32'h32305641);
    check("width", ivf_width, 16'd352);
    check("height", ivf_height, 16'd288);
    send_frame_hdr(32'd16, 64'd0);
    send_payload(16, 8'h00, 8'h01);
    push_exp(128'h0F0E0D0C0B0A09080706050403020100, 16, 1'b1);
    wait_beats(1);
    compare_beats("f16");
    check("f16_count", frame_count, 1);
    check("f16_size", frame_size, 16);

    // 20-byte frame: one full beat plus a 4-byte tail
    send_frame_hdr(32'd20, 64'd1);
    send_payload(20, 8'h40, 8'h01);
    push_exp(128'h4F4E4D4C4B4A49484746454443424140, 16, 1'b0);
    push_exp(128'h00000000000000000000000053525150, 4, 1'b1);
    wait_beats(2);
    compare_beats("f20");
    check("f20_count", frame_count, 2);
    check("f20_size", frame_size, 20);

    // zero-size frame then a 3-byte frame
    do_reset();
    release_reset();
    send_file_hdr(32'h32305641, 16'd352, 16'd288);
    send_frame_hdr(32'd0, 64'd2);
    repeat (3) @(posedge clk);
    #1;
    check("z_no_beat", obs_q.size(), 0);
    check("z_count", frame_count, 1);
    check("z_in_ready", in_ready, 1);
    send_frame_hdr(32'd3, 64'd3);
    send_payload(3, 8'hA0, 8'h01);
    push_exp(128'h00A2A1A0, 3, 1'b1);
    wait_beats(1);
    compare_beats("f3");
    check("f3_count", frame_count, 2);

    // backpressure across a 40-byte frame
    out_ready = 1'b0;
    expect_frame(40, 8'h11, 8'h05);
    fork
      begin
        send_frame_hdr(32'd40, 64'd4);
        send_payload(40, 8'h11, 8'h05);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 500) begin
          @(negedge clk);
          t++;
        end
        check("bp_valid_seen", out_valid, 1);
        snap = out_data;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check($sformatf("bp_stable%0d", i), out_data, snap);
          check($sformatf("bp_in_ready%0d", i), in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_beats(3);
    compare_beats("f40");

    // bad signature byte 2
    do_reset();
    release_reset();
    send_byte(8'h44);
    send_byte(8'h4B);
    check("sig_no_err_yet", hdr_error, 0);
    send_byte(8'h00);
    check("sig_err", hdr_error, 1);
    check("sig_in_ready", in_ready, 0);
    repeat (5) @(posedge clk);
    #1;
    check("sig_err_held", hdr_error, 1);
    check("sig_in_ready_held", in_ready, 0);
    check("sig_out_valid", out_valid, 0);

    // oversize frame
    do_reset();
    release_reset();
    send_file_hdr(32'h32305641, 16'd352, 16'd288);
    for (int i = 0; i < 4; i++) send_byte(8'(32'(MAXF + 1) >> (8*i)));
    for (int i = 0; i < 7; i++) send_byte(8'h00);
    check("big_no_err_yet", hdr_error, 0);
    send_byte(8'h00);
    check("big_err", hdr_error, 1);
    check("big_size", frame_size, 32'(MAXF + 1));
    check("big_in_ready", in_ready, 0);

    // reset mid-payload, then a fresh file
    do_reset();
    release_reset();
    send_file_hdr(32'h32305641, 16'd352, 16'd288);
    send_frame_hdr(32'd16, 64'h99);
    send_payload(7, 8'h00, 8'h01);
    do_reset();
    check("mid_rst_count", frame_count, 0);
    check("mid_rst_size", frame_size, 0);
    check("mid_rst_fourcc", ivf_fourcc, 0);
    check("mid_rst_height", ivf_height, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_bytes", out_bytes, 0);
    check("mid_rst_ts", frame_ts, 0);
    release_reset();
    send_file_hdr(32'h32305641, 16'd176, 16'd144);
    check("new_width", ivf_width, 16'd176);
    send_frame_hdr(32'd4, 64'h0000000000000021);
    send_payload(4, 8'hC0, 8'h01);
    push_exp(128'hC3C2C1C0, 4, 1'b1);
    wait_beats(1);
    compare_beats("new");
    check("new_count", frame_count, 1);
`ifdef IVF_FRAME_TS_EN
    check("new_ts", frame_ts, 64'h21);
`else
    check("new_ts", frame_ts, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
